// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        imem_err_i;

    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [3:0]  trap_code_o;
    logic        is_trap_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i,
        input  imem_ack_i, imem_data_i, imem_err_i,
        output imem_req_o, imem_addr_o,
        output inst_o, pc_o, pc4_o, trap_code_o, is_trap_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i,
        output imem_ack_i, imem_data_i, imem_err_i,
        input  imem_req_o, imem_addr_o,
        input  inst_o, pc_o, pc4_o, trap_code_o, is_trap_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// and fills the IF/ID register with instructions, fetch traps or NOP bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst_n,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        FULL    = 2'd1,
        DRAIN   = 2'd2,
        TRAPPED = 2'd3
    } state_t;

    localparam logic [3:0] CODE_MISALIGNED = 4'd0;
    localparam logic [3:0] CODE_ACCESS     = 4'd1;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_err_q, buf_err_d;

    logic [31:0] inst_q, inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [3:0]  code_q, code_d;
    logic        is_trap_q, is_trap_d;

    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        req;

    // Any IF/ID update always describes the current PC; only the payload varies.
    logic        ent_en;
    logic [31:0] ent_inst;
    logic [3:0]  ent_code;
    logic        ent_trap;

    assign pc_plus4   = pc_q + 32'd4;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign req        = ((state_q == FETCH) || (state_q == DRAIN)) && !misaligned;

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.inst_o      = inst_q;
    assign bus.pc_o        = id_pc_q;
    assign bus.pc4_o       = id_pc4_q;
    assign bus.trap_code_o = code_q;
    assign bus.is_trap_o   = is_trap_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        buf_data_d = buf_data_q;
        buf_err_d  = buf_err_q;
        ent_en     = 1'b0;
        ent_inst   = NOP;
        ent_code   = CODE_MISALIGNED;
        ent_trap   = 1'b0;

        if (bus.redirect_i) begin
            // A redirect always flushes IF/ID, even under stall.
            ent_en = 1'b1;
            if (req && !bus.imem_ack_i) begin
                // Request still in flight: let it finish before moving the address.
                target_d = bus.redirect_pc_i;
                state_d  = DRAIN;
            end else begin
                pc_d    = bus.redirect_pc_i;
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (misaligned) begin
                        if (!bus.stall_i) begin
                            ent_en   = 1'b1;
                            ent_code = CODE_MISALIGNED;
                            ent_trap = 1'b1;
                            state_d  = TRAPPED;
                        end
                    end else if (bus.imem_ack_i) begin
                        if (bus.stall_i) begin
                            buf_data_d = bus.imem_data_i;
                            buf_err_d  = bus.imem_err_i;
                            state_d    = FULL;
                        end else if (bus.imem_err_i) begin
                            ent_en   = 1'b1;
                            ent_code = CODE_ACCESS;
                            ent_trap = 1'b1;
                            state_d  = TRAPPED;
                        end else begin
                            ent_en   = 1'b1;
                            ent_inst = bus.imem_data_i;
                            pc_d     = pc_plus4;
                        end
                    end else if (!bus.stall_i) begin
                        ent_en = 1'b1;
                    end
                end

                FULL: begin
                    // PC still points at the buffered word until it is released.
                    if (!bus.stall_i) begin
                        ent_en = 1'b1;
                        if (buf_err_q) begin
                            ent_code = CODE_ACCESS;
                            ent_trap = 1'b1;
                            state_d  = TRAPPED;
                        end else begin
                            ent_inst = buf_data_q;
                            pc_d     = pc_plus4;
                            state_d  = FETCH;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.imem_ack_i) begin
                        pc_d    = target_q;
                        state_d = FETCH;
                    end
                    if (!bus.stall_i) begin
                        ent_en = 1'b1;
                    end
                end

                TRAPPED: begin
                    if (!bus.stall_i) begin
                        ent_en = 1'b1;
                    end
                end
            endcase
        end

        inst_d    = inst_q;
        id_pc_d   = id_pc_q;
        id_pc4_d  = id_pc4_q;
        code_d    = code_q;
        is_trap_d = is_trap_q;
        if (ent_en) begin
            inst_d    = ent_inst;
            id_pc_d   = pc_q;
            id_pc4_d  = pc_plus4;
            code_d    = ent_code;
            is_trap_d = ent_trap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            target_q   <= RESET_PC;
            buf_data_q <= NOP;
            buf_err_q  <= 1'b0;
            inst_q     <= NOP;
            id_pc_q    <= RESET_PC;
            id_pc4_q   <= RESET_PC + 32'd4;
            code_q     <= CODE_MISALIGNED;
            is_trap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            buf_data_q <= buf_data_d;
            buf_err_q  <= buf_err_d;
            inst_q     <= inst_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            code_q     <= code_d;
            is_trap_q  <= is_trap_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against
// an in-order instruction-stream scoreboard driven by a latency-randomized memory.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int          fixed_lat = 0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    int          wait_cnt  = 0;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {1'b1, a[30:0] ^ 31'h2A5A_0F0F};
    endfunction

    function automatic int next_lat();
        if (fixed_lat >= 0) return fixed_lat;
        return int'($urandom_range(0, 3));
    endfunction

    // Memory model: ack after wait_cnt request cycles, zero meaning same cycle.
    assign bus.imem_ack_i  = rst_n && bus.imem_req_o && (wait_cnt == 0);
    assign bus.imem_data_i = word(bus.imem_addr_o);
    assign bus.imem_err_i  = (bus.imem_addr_o == err_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= next_lat();
        else if (bus.imem_ack_i)
            wait_cnt <= next_lat();
        else if (bus.imem_req_o && wait_cnt > 0)
            wait_cnt <= wait_cnt - 1;
    end

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.inst_o !== NOP || bus.pc_o !== 32'h0 || bus.pc4_o !== 32'h4 ||
            bus.trap_code_o !== 4'd0 || bus.is_trap_o !== 1'b0 || bus.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got inst=%h pc=%h pc4=%h code=%0d trap=%b addr=%h want %h 0 4 0 0 0",
                     bus.inst_o, bus.pc_o, bus.pc4_o, bus.trap_code_o, bus.is_trap_o, bus.imem_addr_o, NOP);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.inst_o !== 32'h00A0_0093 || bus.pc_o !== 32'h0 || bus.pc4_o !== 32'h4) begin
            errors++;
            $display("FAIL first_fetch got inst=%h pc=%h pc4=%h want 00a00093 0 4", bus.inst_o, bus.pc_o, bus.pc4_o);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== 32'h0010_0113 || bus.pc_o !== 32'h4 || bus.pc4_o !== 32'h8) begin
            errors++;
            $display("FAIL second_fetch got inst=%h pc=%h pc4=%h want 00100113 4 8", bus.inst_o, bus.pc_o, bus.pc4_o);
        end
    endtask

    // Continues from test_reset: the 0x8 fetch acks while decode is stalled.
    task automatic test_stall_skid;
        bus.stall_i = 1'b1;
        fixed_lat   = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req_o !== 1'b0 || bus.inst_o !== 32'h0010_0113 || bus.pc_o !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold[%0d] got req=%b inst=%h pc=%h want 0 00100113 4",
                         i, bus.imem_req_o, bus.inst_o, bus.pc_o);
            end
        end
        bus.stall_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_o !== word(32'h8) || bus.pc_o !== 32'h8 || bus.pc4_o !== 32'hC || bus.imem_addr_o !== 32'hC) begin
            errors++;
            $display("FAIL skid_release got inst=%h pc=%h pc4=%h addr=%h want %h 8 c c",
                     bus.inst_o, bus.pc_o, bus.pc4_o, bus.imem_addr_o, word(32'h8));
        end
    endtask

    // The 0xC request waits two cycles; a redirect arrives meanwhile.
    task automatic test_redirect_drain;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hC || bus.inst_o !== NOP || bus.is_trap_o !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold[%0d] got req=%b addr=%h inst=%h trap=%b want 1 c %h 0",
                         i, bus.imem_req_o, bus.imem_addr_o, bus.inst_o, bus.is_trap_o, NOP);
            end
            if (i == 0) @(negedge clk);
        end
        fixed_lat = 0;
        @(negedge clk);
        checks++;
        if (bus.imem_addr_o !== 32'h100 || bus.inst_o !== NOP) begin
            errors++;
            $display("FAIL drain_done got addr=%h inst=%h want 100 %h", bus.imem_addr_o, bus.inst_o, NOP);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== word(32'h100) || bus.pc_o !== 32'h100) begin
            errors++;
            $display("FAIL redirect_target got inst=%h pc=%h want %h 100", bus.inst_o, bus.pc_o, word(32'h100));
        end
    endtask

    task automatic test_misaligned;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h102;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        checks++;
        if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h102 || bus.inst_o !== NOP || bus.is_trap_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_load got req=%b addr=%h inst=%h trap=%b want 0 102 %h 0",
                     bus.imem_req_o, bus.imem_addr_o, bus.inst_o, bus.is_trap_o, NOP);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== NOP || bus.pc_o !== 32'h102 || bus.pc4_o !== 32'h106 ||
            bus.trap_code_o !== 4'd0 || bus.is_trap_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap got inst=%h pc=%h pc4=%h code=%0d trap=%b want %h 102 106 0 1",
                     bus.inst_o, bus.pc_o, bus.pc4_o, bus.trap_code_o, bus.is_trap_o, NOP);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req_o !== 1'b0 || bus.inst_o !== NOP || bus.is_trap_o !== 1'b0) begin
                errors++;
                $display("FAIL trapped_bubble[%0d] got req=%b inst=%h trap=%b want 0 %h 0",
                         i, bus.imem_req_o, bus.inst_o, bus.is_trap_o, NOP);
            end
        end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL trap_exit got req=%b addr=%h want 1 200", bus.imem_req_o, bus.imem_addr_o);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== word(32'h200) || bus.pc_o !== 32'h200) begin
            errors++;
            $display("FAIL resume_fetch got inst=%h pc=%h want %h 200", bus.inst_o, bus.pc_o, word(32'h200));
        end
    endtask

    task automatic test_access_fault;
        err_addr          = 32'h40;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        fixed_lat      = 5;
        checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL fault_req got req=%b addr=%h want 1 40", bus.imem_req_o, bus.imem_addr_o);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== NOP || bus.pc_o !== 32'h40 || bus.pc4_o !== 32'h44 ||
            bus.trap_code_o !== 4'd1 || bus.is_trap_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_trap got inst=%h pc=%h pc4=%h code=%0d trap=%b req=%b want %h 40 44 1 1 0",
                     bus.inst_o, bus.pc_o, bus.pc4_o, bus.trap_code_o, bus.is_trap_o, bus.imem_req_o, NOP);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL fault_idle[%0d] got req=%b want 0", i, bus.imem_req_o);
            end
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_async_reset;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h80;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h80 || bus.inst_o !== NOP) begin
            errors++;
            $display("FAIL pending_0x80 got req=%b addr=%h inst=%h want 1 80 %h",
                     bus.imem_req_o, bus.imem_addr_o, bus.inst_o, NOP);
        end
        fixed_lat = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.inst_o !== NOP || bus.pc_o !== 32'h0 || bus.pc4_o !== 32'h4 ||
            bus.trap_code_o !== 4'd0 || bus.is_trap_o !== 1'b0 || bus.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got inst=%h pc=%h pc4=%h code=%0d trap=%b addr=%h want %h 0 4 0 0 0",
                     bus.inst_o, bus.pc_o, bus.pc4_o, bus.trap_code_o, bus.is_trap_o, bus.imem_addr_o, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.inst_o !== 32'h00A0_0093 || bus.pc_o !== 32'h0 || bus.imem_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL restart got inst=%h pc=%h addr=%h want 00a00093 0 4", bus.inst_o, bus.pc_o, bus.imem_addr_o);
        end
    endtask

    task automatic test_wrap;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pc_o !== 32'hFFFF_FFFC || bus.pc4_o !== 32'h0 || bus.imem_addr_o !== 32'h0 ||
            bus.inst_o !== word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h pc4=%h addr=%h inst=%h want fffffffc 0 0 %h",
                     bus.pc_o, bus.pc4_o, bus.imem_addr_o, bus.inst_o, word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_redirect_stall;
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h300;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        checks++;
        if (bus.inst_o !== NOP || bus.is_trap_o !== 1'b0 || bus.imem_addr_o !== 32'h300) begin
            errors++;
            $display("FAIL redirect_over_stall got inst=%h trap=%b addr=%h want %h 0 300",
                     bus.inst_o, bus.is_trap_o, bus.imem_addr_o, NOP);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_o !== word(32'h300) || bus.pc_o !== 32'h300) begin
            errors++;
            $display("FAIL after_redirect_stall got inst=%h pc=%h want %h 300", bus.inst_o, bus.pc_o, word(32'h300));
        end
    endtask

    // Decode consumes the IF/ID entry on every unstalled edge; the consumed
    // non-bubble entries must form the program-order stream from the last redirect.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] tgt;
        logic        pend;
        logic        s;
        logic        r;
        int          consumed;
        fixed_lat = -1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_pc   = 32'h0;
        pend     = 1'b0;
        consumed = 0;
        for (int c = 0; c < 2000; c++) begin
            if (pend) begin
                checks++;
                if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== pend_addr) begin
                    errors++;
                    $display("FAIL addr_stable cyc=%0d got req=%b addr=%h want 1 %h",
                             c, bus.imem_req_o, bus.imem_addr_o, pend_addr);
                end
            end
            pend      = bus.imem_req_o && !bus.imem_ack_i;
            pend_addr = bus.imem_addr_o;
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 19) == 0);
            tgt = 32'($urandom_range(0, 255)) << 2;
            if (!s) begin
                checks++;
                if (bus.is_trap_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_no_trap cyc=%0d got trap=%b want 0", c, bus.is_trap_o);
                end else if (bus.inst_o !== NOP) begin
                    checks++;
                    consumed++;
                    if (bus.inst_o !== word(exp_pc) || bus.pc_o !== exp_pc || bus.pc4_o !== exp_pc + 32'd4) begin
                        errors++;
                        $display("FAIL rand_stream cyc=%0d got inst=%h pc=%h pc4=%h want %h %h %h",
                                 c, bus.inst_o, bus.pc_o, bus.pc4_o, word(exp_pc), exp_pc, exp_pc + 32'd4);
                    end
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (r) exp_pc = tgt;
            bus.stall_i       = s;
            bus.redirect_i    = r;
            bus.redirect_pc_i = tgt;
            @(negedge clk);
        end
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        checks++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL rand_progress got %0d instructions want at least 200", consumed);
        end
    endtask

    initial begin
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        test_reset();
        test_stall_skid();
        test_redirect_drain();
        test_misaligned();
        test_access_fault();
        test_async_reset();
        test_wrap();
        test_redirect_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage. Owns the PC, runs a request/acknowledge handshake with instruction memory, and redirects on branch/jump/trap targets from decode or the control unit.
- Drives the IF/ID pipeline register that feeds decode's inst, pc_i, pc4_i, trap_code_id_i and is_trap_i inputs.
- Inserts NOP bubbles whenever no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold the IF/ID register; decode cannot accept.
- redirect_i  in  1  single-cycle pulse; replace PC with redirect_pc_i.
- redirect_pc_i  in  32  target from decode pc_j_o or the trap vector.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (= pc).
- imem_ack_i  in  1  response valid; completes the request.
- imem_data_i  in  32  instruction word, valid with ack.
- imem_err_i  in  1  access fault, valid with ack.
- inst_o  out  32  IF/ID instruction.
- pc_o  out  32  IF/ID PC.
- pc4_o  out  32  IF/ID PC+4.
- trap_code_o  out  4  0 = fetch misaligned, 1 = access fault.
- is_trap_o  out  1  IF/ID entry carries a fetch trap.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=FETCH, inst_o=NOP, pc_o=RESET_PC, pc4_o=RESET_PC+4, trap_code_o=0, is_trap_o=0. Reset mid-transaction abandons the request; any late ack after reset release is illegal (the memory is reset on the same rst_n).
- Handshake: imem_addr_o=pc combinationally. imem_req_o=1 only in FETCH or DRAIN, and not when pc[1:0]!=0. Address stays stable until an ack. Ack can arrive in the same cycle as the request or later.
- PC arithmetic: 32-bit modulo 2^32; pc4 = pc+4, so 0xFFFF_FFFC wraps to 0.
- State FETCH:
  - ack, no error, no stall: IF/ID <= {imem_data_i, pc, pc+4, 0, 0}; pc <= pc+4; stay in FETCH. This gives 1 instr/cycle with a zero-wait memory.
  - ack with stall_i=1: capture data and error into the skid buffer, hold IF/ID, go to FULL. Request drops.
  - ack with imem_err_i=1, no stall: IF/ID <= {NOP, pc, pc+4, code 1, is_trap 1}; go to TRAPPED.
  - pc[1:0]!=0: no request issued. When not stalled, IF/ID <= {NOP, pc, pc+4, code 0, is_trap 1}; go to TRAPPED.
  - no ack: IF/ID <= NOP bubble (is_trap 0) unless stalled, in which case IF/ID holds.
- State FULL:
  - When stall_i falls, IF/ID <= buffer contents. pc <= pc+4 for a normal entry; an error entry goes to TRAPPED instead. Return to FETCH.
  - While stall_i stays high, hold.
- State DRAIN (a redirect arrived with a request outstanding):
  - Keep req and the old address asserted.
  - On ack, discard the data and error, pc <= saved target, go to FETCH.
  - IF/ID shows a NOP bubble each unstalled cycle.
- State TRAPPED: req=0; emit NOP bubbles; leave only via redirect_i.
- Redirect priority: redirect_i overrides stall, ack and buffer contents.
  - IF/ID <= NOP bubble (is_trap 0), even if stall_i=1.
  - Same-cycle ack, FETCH with no ack pending, FULL, or TRAPPED: pc <= redirect_pc_i, go to FETCH.
  - FETCH with req high and no ack: save the target, go to DRAIN.
  - DRAIN plus a new redirect: overwrite the saved target.
  - A misaligned target is loaded anyway and raises trap code 0 on the next FETCH cycle.
- stall_i does not stop an outstanding request from completing; the result lands in the skid buffer.

Test Plan:
- Reset, zero-wait memory returning 0x00A00093 at 0x0 and 0x00100113 at 0x4 -> inst_o=0x00A00093, pc_o=0 after the first edge; inst_o=0x00100113, pc_o=4, pc4_o=8 after the second.
- Ack at pc=0x8 with stall_i high for 3 cycles -> IF/ID holds its prior value, imem_req_o=0; one cycle after the stall drops, pc_o=0x8 with the captured word and pc advances to 0xC.
- Redirect to 0x100 while the 0xC request waits 2 cycles -> ack of 0xC is discarded, next imem_addr_o=0x100, only NOPs reach IF/ID in between.
- Redirect to 0x102 -> no request, IF/ID = {NOP, pc 0x102, trap_code 0, is_trap 1}, then bubbles until a redirect to 0x200 resumes fetching.
- Ack with imem_err_i=1 at 0x40 -> is_trap_o=1, trap_code_o=1, pc_o=0x40; request stays low until a redirect.
- Assert rst_n low with a request pending at 0x80 -> all outputs return to reset values immediately; fetching restarts at RESET_PC.
